// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit feeding the register-file write port.
// Radix-2: one shift-add or restoring shift-subtract step per clock.
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dst,
  output logic             busy,
  output logic             write,
  output logic [AW-1:0]    wreg,
  output logic [WIDTH-1:0] wd,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, wd_q, wd_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d, wreg_q, wreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, write_q, write_d, dz_q, dz_d;

  // {hi,lo} is the product register for multiply, {remainder,quotient} for divide
  logic [WIDTH:0]   mul_sum, div_t, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_t    = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_t - {1'b0, b_q};
    div_ge   = (div_t >= {1'b0, b_q});
    if (op_q[1]) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    write_d = 1'b0;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          dst_d   = dst;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = op[1] ? a : b;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (op_q[1] && (b_q == '0)) begin
          write_d = 1'b1;
          dz_d    = 1'b1;
          wreg_d  = dst_q;
          wd_d    = op_q[0] ? a_q : '1;
          state_d = WB;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            write_d = 1'b1;
            wreg_d  = dst_q;
            wd_d    = op_q[0] ? step_hi : step_lo;
            state_d = WB;
          end
        end
      end
      WB: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      wreg_q  <= '0;
      wd_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      write_q <= write_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign write    = write_q;
  assign wreg     = wreg_q;
  assign wd       = wd_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against
// an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [2:0]  dst;
  logic        busy, write, div_zero;
  logic [2:0]  wreg;
  logic [15:0] wd;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .write(write), .wreg(wreg), .wd(wd), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return (y == 0) ? 16'hFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called at a negedge. inject_at > 0 drives an extra start mid-operation.
  task automatic run_op(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [2:0] d, input int inject_at);
    logic [15:0] exp_wd;
    logic        exp_dz;
    int          exp_lat;
    int          n;
    exp_wd  = model(o, aa, bb);
    exp_dz  = o[1] && (bb == 0);
    exp_lat = exp_dz ? 1 : 16;
    op = o; a = aa; b = bb; dst = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; op = ~o; dst = ~d;
    chk("busy_set", busy, 1);
    n = 0;
    while (!write && n < 40) begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        start = 1'b1; a = 16'h00FF; b = 16'h00FF; op = 2'b10; dst = ~d;
      end else begin
        start = 1'b0;
      end
      if (!write && n == 8) chk("busy_mid", busy, 1);
    end
    start = 1'b0;
    chk("latency", n, exp_lat);
    chk("wreg", wreg, d);
    chk("wd", wd, exp_wd);
    chk("div_zero", div_zero, exp_dz);
    @(negedge clk);
    chk("write_pulse", write, 0);
    chk("busy_clr", busy, 0);
    chk("dz_clr", div_zero, 0);
    chk("wd_hold", wd, exp_wd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int extra_writes;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = 0; a = 0; b = 0; dst = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_write", write, 0);
    chk("rst_wreg", wreg, 0);
    chk("rst_wd", wd, 0);
    chk("rst_dz", div_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'd0, 16'h0003, 16'h0005, 3'd3, 0);
    run_op(2'd1, 16'hFFFF, 16'hFFFF, 3'd1, 0);
    run_op(2'd0, 16'hFFFF, 16'hFFFF, 3'd2, 0);
    run_op(2'd2, 16'h0064, 16'h0007, 3'd4, 0);
    run_op(2'd3, 16'h0064, 16'h0007, 3'd6, 0);
    run_op(2'd2, 16'h1234, 16'h0000, 3'd5, 0);
    run_op(2'd3, 16'h1234, 16'h0000, 3'd5, 0);
    run_op(2'd0, 16'h0000, 16'hABCD, 3'd0, 0);

    // start while busy must be ignored: exactly one write-back
    run_op(2'd0, 16'h0002, 16'h0003, 3'd7, 4);
    extra_writes = 0;
    repeat (20) begin
      @(negedge clk);
      if (write) extra_writes++;
    end
    chk("ignored_start", extra_writes, 0);

    // asynchronous reset mid-divide
    op = 2'd2; a = 16'h1234; b = 16'h0007; dst = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_write", write, 0);
    chk("abort_wd", wd, 0);
    extra_writes = 0;
    repeat (3) begin
      @(negedge clk);
      if (write) extra_writes++;
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (write) extra_writes++;
    end
    chk("abort_nowrite", extra_writes, 0);
    run_op(2'd0, 16'h0004, 16'h0004, 3'd1, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op(ro, ra, rb, 3'($urandom_range(0, 7)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
